qpsk_symbol_mapper: RTL and testbench

Downstream stage of the QPSK bit splitter. Takes the 4-bit even (I) and odd (Q) words assembled by the splitter's shift registers once both ready flags are set. Emits 4 QPSK symbols per word pair: signed I/Q levels plus a 2-bit Gray phase code. Each symbol is held for a programmable number of clocks, feeding the carrier mixer / DAC stage.

---
 rtl/qpsk_symbol_mapper.sv | 170 +++++++++++++++++
 tb/tb_qpsk_symbol_mapper.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_mapper.sv
// qpsk_symbol_mapper: turns a captured 4-bit I word and a 4-bit Q word into
// four QPSK symbols. Each symbol is a signed I/Q level pair plus a 2-bit Gray
// phase code, and each is held for SYM_CYCLES clocks.
// Optional build macro DIFF_ENC_EN selects differential (DQPSK) encoding.
// With DIFF_ENC_EN defined, a 2-bit phase accumulator integrates the dibit
// codes across symbols and frames. Without it, the mapping is absolute.
module qpsk_symbol_mapper #(
  parameter int SYM_CYCLES = 4,
  parameter int OUT_W      = 8,
  parameter int AMP        = 90
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              even_word,
  input  logic [3:0]              odd_word,
  input  logic                    even_rdy,
  input  logic                    odd_rdy,
  output logic                    load_ack,
  output logic                    busy,
  output logic                    sym_valid,
  output logic                    sym_strobe,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic [1:0]              phase,
  output logic                    frame_done
);

  localparam int CW = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SYM_CYCLES - 1);
  localparam logic signed [OUT_W-1:0] POS_LVL = OUT_W'(AMP);
  localparam logic signed [OUT_W-1:0] NEG_LVL = OUT_W'(-AMP);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                  state, state_n;
  logic [3:0]              even_q, even_n;
  logic [3:0]              odd_q, odd_n;
  logic [1:0]              sym_idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    load_ack_n, busy_n, strobe_n, done_n;
  logic signed [OUT_W-1:0] i_n, q_n;
  logic [1:0]              phase_n;
  logic                    take_load, clear_out, drive;
  logic                    i_bit, q_bit;
  logic [1:0]              dibit, ph_sel;

`ifdef DIFF_ENC_EN
  logic [1:0] acc, acc_n;
`endif

  // State, captured words, counters and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      even_q     <= '0;
      odd_q      <= '0;
      sym_idx    <= '0;
      cnt        <= '0;
      load_ack   <= 1'b0;
      busy       <= 1'b0;
      sym_valid  <= 1'b0;
      sym_strobe <= 1'b0;
      i_out      <= '0;
      q_out      <= '0;
      phase      <= '0;
      frame_done <= 1'b0;
`ifdef DIFF_ENC_EN
      acc        <= '0;
`endif
    end else begin
      state      <= state_n;
      even_q     <= even_n;
      odd_q      <= odd_n;
      sym_idx    <= idx_n;
      cnt        <= cnt_n;
      load_ack   <= load_ack_n;
      busy       <= busy_n;
      sym_valid  <= busy_n;
      sym_strobe <= strobe_n;
      i_out      <= i_n;
      q_out      <= q_n;
      phase      <= phase_n;
      frame_done <= done_n;
`ifdef DIFF_ENC_EN
      acc        <= acc_n;
`endif
    end
  end

  // Next-state logic: load, per-symbol advance, end-of-frame reload or return to idle
  always_comb begin
    state_n    = state;
    even_n     = even_q;
    odd_n      = odd_q;
    idx_n      = sym_idx;
    cnt_n      = cnt;
    load_ack_n = 1'b0;
    strobe_n   = 1'b0;
    take_load  = 1'b0;
    clear_out  = 1'b0;
    drive      = 1'b0;
    i_n        = i_out;
    q_n        = q_out;
    phase_n    = phase;

    case (state)
      IDLE: begin
        if (even_rdy && odd_rdy) take_load = 1'b1;
      end
      EMIT: begin
        if (cnt == CNT_MAX) begin
          if (sym_idx == 2'd3) begin
            if (even_rdy && odd_rdy) take_load = 1'b1;
            else                     clear_out = 1'b1;
          end else begin
            idx_n = sym_idx + 2'd1;
            cnt_n = '0;
            drive = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: clear_out = 1'b1;
    endcase

    if (take_load) begin
      even_n     = even_word;
      odd_n      = odd_word;
      idx_n      = '0;
      cnt_n      = '0;
      state_n    = EMIT;
      load_ack_n = 1'b1;
      drive      = 1'b1;
    end

    if (clear_out) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end

    // Gray code of the (i,q) dibit: 00->0, 10->1, 11->2, 01->3
    i_bit = even_n[idx_n];
    q_bit = odd_n[idx_n];
    dibit = {q_bit, i_bit ^ q_bit};

`ifdef DIFF_ENC_EN
    ph_sel = acc + dibit;
    acc_n  = drive ? ph_sel : acc;
`else
    ph_sel = dibit;
`endif

    if (state_n == IDLE) begin
      i_n     = '0;
      q_n     = '0;
      phase_n = '0;
    end else if (drive) begin
      i_n      = (ph_sel[1] ^ ph_sel[0]) ? NEG_LVL : POS_LVL;
      q_n      = ph_sel[1] ? NEG_LVL : POS_LVL;
      phase_n  = ph_sel;
      strobe_n = 1'b1;
    end

    busy_n = (state_n == EMIT);
    done_n = (state_n == EMIT) && (idx_n == 2'd3) && (cnt_n == CNT_MAX);
  end

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// tb_qpsk_symbol_mapper: directed test of the QPSK symbol mapper with
// SYM_CYCLES=2 and AMP=90. It covers reset, a single frame, a back-to-back
// frame, a single ready flag, and an asynchronous reset mid-frame.
// Expected levels follow the DIFF_ENC_EN build macro.
module tb_qpsk_symbol_mapper;

  localparam int SYM_CYCLES = 2;
  localparam int OUT_W      = 8;
  localparam int AMP        = 90;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [3:0]              even_word, odd_word;
  logic                    even_rdy, odd_rdy;
  logic                    load_ack, busy, sym_valid, sym_strobe, frame_done;
  logic signed [OUT_W-1:0] i_out, q_out;
  logic [1:0]              phase;

  int checks = 0;
  int passes = 0;

  // Hand-computed symbols for even=1010, odd=0110
`ifdef DIFF_ENC_EN
  int exp_i[4]  = '{90, -90, -90, -90};
  int exp_q[4]  = '{90, -90, 90, -90};
  int exp_ph[4] = '{0, 2, 1, 2};
  // second frame (words 0101/1001): acc 2 + dibit 2 -> 0
  int nxt_i = 90, nxt_q = 90, nxt_ph = 0;
`else
  int exp_i[4]  = '{90, -90, 90, -90};
  int exp_q[4]  = '{90, -90, -90, 90};
  int exp_ph[4] = '{0, 2, 3, 1};
  // second frame (words 0101/1001): bits (1,1) -> 2
  int nxt_i = -90, nxt_q = -90, nxt_ph = 2;
`endif

  qpsk_symbol_mapper #(
    .SYM_CYCLES(SYM_CYCLES),
    .OUT_W(OUT_W),
    .AMP(AMP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .even_word(even_word),
    .odd_word(odd_word),
    .even_rdy(even_rdy),
    .odd_rdy(odd_rdy),
    .load_ack(load_ack),
    .busy(busy),
    .sym_valid(sym_valid),
    .sym_strobe(sym_strobe),
    .i_out(i_out),
    .q_out(q_out),
    .phase(phase),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] ev, input logic [3:0] od,
                               input logic er, input logic orr);
    even_word = ev;
    odd_word  = od;
    even_rdy  = er;
    odd_rdy   = orr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " sym_valid"}, int'(sym_valid), 0);
    checkOutput({tag, " load_ack"}, int'(load_ack), 0);
    checkOutput({tag, " sym_strobe"}, int'(sym_strobe), 0);
    checkOutput({tag, " frame_done"}, int'(frame_done), 0);
    checkOutput({tag, " i_out"}, int'(i_out), 0);
    checkOutput({tag, " q_out"}, int'(q_out), 0);
    checkOutput({tag, " phase"}, int'(phase), 0);
  endtask

  // Ready flags must already be high; the first tick is the load edge.
  // The input words change after the load to show that they were captured.
  task automatic checkFrame(input string tag, input logic hold_rdy);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) applyStimulus(4'b0101, 4'b1001, hold_rdy, hold_rdy);
      checkOutput($sformatf("%s c%0d load_ack", tag, c), int'(load_ack), int'(c == 0));
      checkOutput($sformatf("%s c%0d busy", tag, c), int'(busy), 1);
      checkOutput($sformatf("%s c%0d sym_valid", tag, c), int'(sym_valid), 1);
      checkOutput($sformatf("%s c%0d sym_strobe", tag, c), int'(sym_strobe), int'(c % 2 == 0));
      checkOutput($sformatf("%s c%0d frame_done", tag, c), int'(frame_done), int'(c == 7));
      checkOutput($sformatf("%s c%0d i_out", tag, c), int'(i_out), exp_i[c/2]);
      checkOutput($sformatf("%s c%0d q_out", tag, c), int'(q_out), exp_q[c/2]);
      checkOutput($sformatf("%s c%0d phase", tag, c), int'(phase), exp_ph[c/2]);
    end
  endtask

  initial begin
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    #2;
    checkIdle("reset");
    #10;
    reset_n = 1'b1;

    // Idle with ready flags low
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput($sformatf("t1 c%0d load_ack", c), int'(load_ack), 0);
      checkOutput($sformatf("t1 c%0d busy", c), int'(busy), 0);
    end
    checkIdle("t1 end");

    // Single frame, then idle
    resetPulse();
    applyStimulus(4'b1010, 4'b0110, 1'b1, 1'b1);
    checkFrame("t2", 1'b0);
    tick();
    checkIdle("t2 end");

    // Back-to-back frames with ready held high
    resetPulse();
    applyStimulus(4'b1010, 4'b0110, 1'b1, 1'b1);
    checkFrame("t3", 1'b1);
    tick();
    checkOutput("t3 reload load_ack", int'(load_ack), 1);
    checkOutput("t3 reload busy", int'(busy), 1);
    checkOutput("t3 reload sym_strobe", int'(sym_strobe), 1);
    checkOutput("t3 reload i_out", int'(i_out), nxt_i);
    checkOutput("t3 reload q_out", int'(q_out), nxt_q);
    checkOutput("t3 reload phase", int'(phase), nxt_ph);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int c = 1; c < 8; c++) begin
      tick();
      checkOutput($sformatf("t3 f2 c%0d busy", c), int'(busy), 1);
    end
    tick();
    checkIdle("t3 end");

    // Only one ready flag: no load until both are high
    applyStimulus(4'b1010, 4'b0110, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("t4 c%0d load_ack", c), int'(load_ack), 0);
      checkOutput($sformatf("t4 c%0d busy", c), int'(busy), 0);
    end
    applyStimulus(4'b1010, 4'b0110, 1'b1, 1'b1);
    tick();
    checkOutput("t4 load_ack", int'(load_ack), 1);
    checkOutput("t4 busy", int'(busy), 1);
    applyStimulus(4'b1010, 4'b0110, 1'b0, 1'b0);
    repeat (8) tick();
    checkOutput("t4 end busy", int'(busy), 0);

    // Asynchronous reset in cycle 3 of a frame
    applyStimulus(4'b1010, 4'b0110, 1'b1, 1'b1);
    tick();
    applyStimulus(4'b1010, 4'b0110, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("t5 pre busy", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkIdle("t5 async");
    #10;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("t5 c%0d sym_valid", c), int'(sym_valid), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
